// File: rtl/stream_cipher_core_p.sv
// Parametrised LFSR stream cipher: XORs each accepted word with DATA_W keystream bits
// from a Fibonacci LFSR, with valid/ready handshakes on both sides and a word counter.
module stream_cipher_core_p #(
  parameter int LFSR_W = 8,
  parameter int DATA_W = 8,
  parameter logic [LFSR_W-1:0] TAPS = 8'hB8,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CNT_W-1:0]  word_count_o,
  output logic [LFSR_W-1:0] lfsr_state_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] keystream;
  logic [LFSR_W-1:0] lfsrAdvanced;
  logic [LFSR_W-1:0] seedSafe;
  logic              inXfer;
  logic              outXfer;

  // Unroll DATA_W LFSR steps in one cycle; bit i of the keystream is state[0] after i steps.
  always_comb begin
    logic [LFSR_W-1:0] st;
    st        = lfsr_q;
    keystream = '0;
    for (int i = 0; i < DATA_W; i++) begin
      keystream[i] = st[0];
      st = {st[LFSR_W-2:0], ^(st & TAPS)};
    end
    lfsrAdvanced = st;
  end

  // An all-zero seed would lock the LFSR at zero forever, so it is replaced by 1.
  assign seedSafe   = (seed_i == '0) ? LFSR_W'(1) : seed_i;

  assign in_ready_o = !load_i && (!valid_q || out_ready_i);
  assign inXfer     = in_valid_i && in_ready_o;
  assign outXfer    = valid_q && out_ready_i;

  always_comb begin
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      lfsr_d = seedSafe;
      cnt_d  = '0;
    end
    if (inXfer) begin
      data_d  = in_data_i ^ keystream;
      valid_d = 1'b1;
      lfsr_d  = lfsrAdvanced;
      cnt_d   = cnt_q + CNT_W'(1);
    end else if (outXfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q  <= LFSR_W'(1);
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data_o   = data_q;
  assign out_valid_o  = valid_q;
  assign word_count_o = cnt_q;
  assign lfsr_state_o = lfsr_q;

endmodule

// File: tb/tb_stream_cipher_core_p.sv
// Bench for stream_cipher_core_p: bit-serial keystream model with a per-cycle compare,
// directed scenarios with literal expectations, and a 16-bit LFSR random sweep.
module tb_stream_cipher_core_p;

  logic        clk;
  logic        rst;
  logic [7:0]  seed;
  logic        load;
  logic [7:0]  inData;
  logic        inValid;
  logic        inReady;
  logic [7:0]  outData;
  logic        outValid;
  logic        outReady;
  logic [15:0] wordCount;
  logic [7:0]  lfsrState;

  logic [15:0] swSeed;
  logic        swLoad;
  logic        swValid;
  logic [7:0]  swDataA;
  logic [31:0] swDataB;
  logic        swReadyA, swReadyB, swValidA, swValidB;
  logic [7:0]  swOutA;
  logic [31:0] swOutB;
  logic [15:0] swCntA, swCntB, swStA, swStB;

  int checks = 0;
  int failures = 0;

  stream_cipher_core_p dut (
    .clk_i(clk), .rst_i(rst), .seed_i(seed), .load_i(load),
    .in_data_i(inData), .in_valid_i(inValid), .in_ready_o(inReady),
    .out_data_o(outData), .out_valid_o(outValid), .out_ready_i(outReady),
    .word_count_o(wordCount), .lfsr_state_o(lfsrState)
  );

  stream_cipher_core_p #(.LFSR_W(16), .DATA_W(8), .TAPS(16'hB400), .CNT_W(16)) dutA (
    .clk_i(clk), .rst_i(rst), .seed_i(swSeed), .load_i(swLoad),
    .in_data_i(swDataA), .in_valid_i(swValid), .in_ready_o(swReadyA),
    .out_data_o(swOutA), .out_valid_o(swValidA), .out_ready_i(1'b1),
    .word_count_o(swCntA), .lfsr_state_o(swStA)
  );

  stream_cipher_core_p #(.LFSR_W(16), .DATA_W(32), .TAPS(16'hB400), .CNT_W(16)) dutB (
    .clk_i(clk), .rst_i(rst), .seed_i(swSeed), .load_i(swLoad),
    .in_data_i(swDataB), .in_valid_i(swValid), .in_ready_o(swReadyB),
    .out_data_o(swOutB), .out_valid_o(swValidB), .out_ready_i(1'b1),
    .word_count_o(swCntB), .lfsr_state_o(swStB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift the register one bit at a time, collecting state[0] before each shift.
  function automatic void ksModel(input logic [31:0] stIn, input int lw, input int dw,
                                  input logic [31:0] taps,
                                  output logic [31:0] ks, output logic [31:0] nst);
    logic [31:0] st;
    logic [31:0] mask;
    logic        fb;
    mask = (lw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << lw) - 32'd1);
    st = stIn & mask;
    ks = '0;
    for (int i = 0; i < dw; i++) begin
      ks[i] = st[0];
      fb = ^(st & taps);
      st = ((st << 1) | {31'b0, fb}) & mask;
    end
    nst = st;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [7:0] sd, input logic iv,
                               input logic [7:0] id, input logic ordy);
    load     = ld;
    seed     = sd;
    inValid  = iv;
    inData   = id;
    outReady = ordy;
    @(posedge clk);
    #1;
  endtask

  // Reference model of the 8-bit instance: what the outputs must be after each edge.
  logic [7:0]  mSt, mOut;
  logic        mVal, mRdy;
  logic [15:0] mCnt;
  logic [31:0] mKs, mNst;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mSt = 8'h01; mOut = 8'h00; mVal = 1'b0; mCnt = 16'd0;
    end else begin
      mRdy = !load && (!mVal || outReady);
      if (load) begin
        mSt  = (seed == 8'h00) ? 8'h01 : seed;
        mCnt = 16'd0;
      end
      if (mRdy && inValid) begin
        ksModel({24'b0, mSt}, 8, 8, 32'hB8, mKs, mNst);
        mOut = inData ^ mKs[7:0];
        mVal = 1'b1;
        mSt  = mNst[7:0];
        mCnt = mCnt + 16'd1;
      end else if (mVal && outReady) begin
        mVal = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("model out_valid", {31'b0, outValid}, {31'b0, mVal});
      checkOutput("model out_data", {24'b0, outData}, {24'b0, mOut});
      checkOutput("model lfsr_state", {24'b0, lfsrState}, {24'b0, mSt});
      checkOutput("model word_count", {16'b0, wordCount}, {16'b0, mCnt});
      checkOutput("model in_ready", {31'b0, inReady},
                  {31'b0, !load && (!mVal || outReady)});
    end
  end

  initial begin
    logic [31:0] ks, nst, stA, stB, ksA, nA, ksB, nB;
    logic [7:0]  dA;
    logic [31:0] dB;

    rst = 1'b1;
    load = 0; seed = 0; inValid = 0; inData = 0; outReady = 1;
    swLoad = 0; swSeed = 0; swValid = 0; swDataA = 0; swDataB = 0;

    ksModel(32'h01, 8, 8, 32'hB8, ks, nst);
    checkOutput("pin model ks seed01", ks, 32'h71);
    checkOutput("pin model next seed01", nst, 32'h1C);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("reset out_data", {24'b0, outData}, 32'd0);
    checkOutput("reset lfsr", {24'b0, lfsrState}, 32'h01);
    checkOutput("reset word_count", {16'b0, wordCount}, 32'd0);
    rst = 1'b0;

    // Scenario 1: seed 1, plaintext 0
    applyStimulus(1, 8'h01, 0, 8'h00, 1);
    checkOutput("s1 lfsr after load", {24'b0, lfsrState}, 32'h01);
    applyStimulus(0, 8'h00, 1, 8'h00, 1);
    checkOutput("s1 out_data", {24'b0, outData}, 32'h71);
    checkOutput("s1 out_valid", {31'b0, outValid}, 32'd1);
    checkOutput("s1 lfsr", {24'b0, lfsrState}, 32'h1C);
    checkOutput("s1 word_count", {16'b0, wordCount}, 32'd1);
    applyStimulus(0, 8'h00, 0, 8'h00, 1);

    // Scenario 2: decrypt round trip then back-to-back words
    applyStimulus(1, 8'h01, 0, 8'h00, 1);
    applyStimulus(0, 8'h00, 1, 8'h71, 1);
    checkOutput("s2 decrypt", {24'b0, outData}, 32'h00);
    applyStimulus(0, 8'h00, 1, 8'h00, 1);
    checkOutput("s2 in_ready held", {31'b0, inReady}, 32'd1);
    checkOutput("s2 valid first", {31'b0, outValid}, 32'd1);
    applyStimulus(0, 8'h00, 1, 8'h00, 1);
    checkOutput("s2 valid second", {31'b0, outValid}, 32'd1);
    checkOutput("s2 word_count", {16'b0, wordCount}, 32'd3);
    applyStimulus(0, 8'h00, 0, 8'h00, 1);

    // Scenario 3: zero seed is replaced by 1
    applyStimulus(1, 8'h00, 0, 8'h00, 1);
    checkOutput("s3 zero seed lfsr", {24'b0, lfsrState}, 32'h01);
    applyStimulus(0, 8'h00, 1, 8'h00, 1);
    checkOutput("s3 out_data", {24'b0, outData}, 32'h71);
    applyStimulus(0, 8'h00, 0, 8'h00, 1);

    // Scenario 4: backpressure with input held
    applyStimulus(1, 8'h37, 0, 8'h00, 1);
    applyStimulus(0, 8'h00, 1, 8'hA5, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 8'h00, 1, 8'h3C, 0);
      checkOutput("s4 in_ready stalled", {31'b0, inReady}, 32'd0);
      checkOutput("s4 word_count frozen", {16'b0, wordCount}, 32'd1);
    end
    applyStimulus(0, 8'h00, 1, 8'h3C, 1);
    checkOutput("s4 word_count resumed", {16'b0, wordCount}, 32'd2);
    applyStimulus(0, 8'h00, 0, 8'h00, 1);

    // Scenario 5: load beats in_valid, word accepted next cycle under the new seed
    applyStimulus(1, 8'h5A, 1, 8'hC3, 1);
    checkOutput("s5 lfsr new seed", {24'b0, lfsrState}, 32'h5A);
    checkOutput("s5 word_count", {16'b0, wordCount}, 32'd0);
    checkOutput("s5 no transfer", {31'b0, outValid}, 32'd0);
    ksModel(32'h5A, 8, 8, 32'hB8, ks, nst);
    applyStimulus(0, 8'h00, 1, 8'hC3, 1);
    checkOutput("s5 out_data", {24'b0, outData}, 32'hC3 ^ ks);
    checkOutput("s5 word_count after", {16'b0, wordCount}, 32'd1);

    // Scenario 6: asynchronous reset while a word is held
    applyStimulus(0, 8'h00, 1, 8'h11, 0);
    inValid = 0;
    #2 rst = 1'b1;
    #1;
    checkOutput("s6 out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("s6 out_data", {24'b0, outData}, 32'd0);
    checkOutput("s6 lfsr", {24'b0, lfsrState}, 32'h01);
    checkOutput("s6 word_count", {16'b0, wordCount}, 32'd0);
    outReady = 1;
    @(posedge clk);
    #1 rst = 1'b0;

    // 16-bit LFSR sweep at DATA_W 8 and 32
    swSeed = 16'hACE1;
    swLoad = 1'b1;
    @(posedge clk);
    #1;
    swLoad = 1'b0;
    stA = 32'hACE1;
    stB = 32'hACE1;
    for (int k = 0; k < 1000; k++) begin
      dA = 8'($urandom);
      dB = $urandom;
      swDataA = dA;
      swDataB = dB;
      swValid = 1'b1;
      @(posedge clk);
      #1;
      ksModel(stA, 16, 8, 32'hB400, ksA, nA);
      ksModel(stB, 16, 32, 32'hB400, ksB, nB);
      stA = nA;
      stB = nB;
      checkOutput("sweep8 data", {24'b0, swOutA}, {24'b0, dA ^ ksA[7:0]});
      checkOutput("sweep8 lfsr", {16'b0, swStA}, stA);
      checkOutput("sweep32 data", swOutB, dB ^ ksB);
      checkOutput("sweep32 lfsr", {16'b0, swStB}, stB);
    end
    checkOutput("sweep8 valid", {31'b0, swValidA}, 32'd1);
    checkOutput("sweep32 count", {16'b0, swCntB}, 32'd1000);
    swValid = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_cipher_core_p.md
Name: stream_cipher_core_p

Overview:
- Parametrised successor to the team's 8-bit LFSR stream cipher core.
- Encrypts or decrypts a stream of DATA_W-bit words by XOR with keystream from a Fibonacci LFSR. LFSR width and taps are configurable.
- Adds valid/ready backpressure on both sides, an output holding register, lock-up protection on zero seeds, and a processed-word counter.
- Sits between a byte/word source (UART/bus bridge) and a sink. The same block with the same seed decrypts.

Parameters:
- LFSR_W, 8, LFSR state width (>=2).
- DATA_W, 8, data word width. Any value >=1; need not relate to LFSR_W.
- TAPS, 8'hB8, LFSR_W-bit tap mask. Feedback = XOR-reduce(state & TAPS).
- CNT_W, 16, width of word counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- seed  in  LFSR_W  key value.
- load  in  1  load seed into LFSR this cycle.
- in_data  in  DATA_W  plaintext/ciphertext word.
- in_valid  in  1  in_data valid.
- in_ready  out  DATA_W? no: 1  block can accept a word this cycle.
- out_data  out  DATA_W  result word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts out_data.
- word_count  out  CNT_W  words processed since reset/last load.
- lfsr_state  out  LFSR_W  current LFSR register (debug).

Behaviour:
- Reset (async, rst=1): lfsr=1, out_data=0, out_valid=0, word_count=0. in_ready reads 1 whenever rst=0, load=0 and out_valid=0.
- Reset mid-operation aborts any held output word; no partial state survives.
- Step function: ks bit = state[0]; next = {state[LFSR_W-2:0], ^(state & TAPS)}.
- Per accepted word, apply DATA_W steps starting from the current state: ks[i] = state[0] after i steps, i=0..DATA_W-1.
  - out_data = in_data ^ ks.
  - lfsr <= state after DATA_W steps.
  - Single cycle, combinational unrolled.
- in_ready = !load && (!out_valid || out_ready). Combinational path from out_ready and load is permitted.
- Input transfer occurs when in_valid && in_ready.
- Latency: one cycle. A word accepted at edge N is on out_data with out_valid=1 after edge N. Full throughput is 1 word/clock while out_ready=1.
- Output transfer occurs when out_valid && out_ready.
- Same edge has an output transfer and no input transfer: out_valid <= 0, out_data holds its last value.
- out_valid=1 and out_ready=0: out_data, out_valid and lfsr are all frozen. in_ready=0.
- load=1 (rst=0):
  - lfsr <= seed, or 1 if seed==0 (lock-up avoidance).
  - word_count <= 0.
  - No input transfer that cycle (in_ready=0).
  - Held output word unaffected; it may still transfer on out_ready.
- load and in_valid in the same cycle: load wins; the word stays pending on the input side.
- word_count increments by 1 on each input transfer and wraps modulo 2^CNT_W without saturation.
- lfsr_state is the register value itself (post-edge), not the next state.

Test Plan:
1. Reset, load seed=0x01, present in_data=0x00 with out_ready=1 -> out_data=0x71, out_valid=1 next cycle, lfsr_state=0x1C, word_count=1.
2. Reload seed=0x01, send 0x71 -> out_data=0x00 (decrypt round-trip). Then send 0x00,0x00 back-to-back -> in_ready held 1, out_valid high two consecutive cycles, word_count=3.
3. Load seed=0x00 -> lfsr_state=0x01. Then plaintext 0x00 -> 0x71, matching scenario 1.
4. Backpressure: out_ready=0 after first word with in_valid held -> in_ready=0, out_data/lfsr_state frozen for 5 cycles. Raise out_ready -> next word accepted the same cycle. No word is lost or duplicated; the sequence matches the reference model.
5. load and in_valid asserted together -> no transfer, word_count=0, new seed in lfsr. The word is accepted next cycle with keystream from the new seed.
6. Assert rst mid-stream with out_valid=1 -> out_valid=0, out_data=0, lfsr_state=0x01, word_count=0 immediately (asynchronously).

Extra test: parameter sweep LFSR_W=16, TAPS=16'hB400, DATA_W=8 and 32. Compare 1000 random words against a bit-serial software model.
